// File: rtl/iram_loader_pkg.sv
// Shared types and constants for the instruction-RAM boot loader.
// DEPTH_WORDS_DEF must track the instruction RAM depth.
package iram_loader_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 8191;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  // Little-endian assembly: each new byte enters at the top and older bytes move down.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word, input logic [7:0] b);
    return {b, word[31:8]};
  endfunction

endpackage

// File: rtl/iram_loader_timeout.sv
// Idle-gap watchdog: reloads on clear, counts down while enabled, and flags
// the idle cycle that completes TIMEOUT_CYCLES consecutive idle cycles.
module iram_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= LOAD_VAL;
    end else if (clear) begin
      cnt <= LOAD_VAL;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = enable && (cnt == CNT_W'(1));

endmodule

// File: rtl/iram_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> instruction RAM writes.
// Optional trailing checksum byte when IRAM_LOADER_CSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for load_start, core released
// LEN   | shifting in the 4-byte word count
// DATA  | assembling the next 4-byte word
// WRITE | one-cycle RAM write strobe
// CSUM  | waiting for the trailing checksum byte
// DONE  | one-cycle completion pulse, core released
// ERR   | sticky failure, core held in reset
module iram_loader
  import iram_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = DEPTH_WORDS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        iram_we,
  output logic [31:0] iram_waddr,
  output logic [31:0] iram_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [1:0]  err_code,
  output logic [31:0] words_loaded
);

`ifdef IRAM_LOADER_CSUM_EN
  localparam state_t ST_TAIL = ST_CSUM;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  state_t      state, state_nxt;
  logic [31:0] len_q, word_q, wcnt_q;
  logic [1:0]  bcnt_q, err_q, err_val;
  logic        accept, start, err_set;
  logic        to_clear, to_en, to_exp;
  logic [31:0] len_asm, word_asm;
  logic        last_byte, last_word;

`ifdef IRAM_LOADER_CSUM_EN
  logic [7:0] csum_q;
  logic [7:0] csum_fin;
  assign csum_fin = csum_q + rx_data;
  assign rx_ready = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
`else
  assign rx_ready = (state == ST_LEN) || (state == ST_DATA);
`endif

  assign accept    = rx_valid && rx_ready;
  assign len_asm   = shift_in_byte(len_q, rx_data);
  assign word_asm  = shift_in_byte(word_q, rx_data);
  assign last_byte = (bcnt_q == 2'd3);
  assign last_word = ((wcnt_q + 32'd1) == len_q);

  // Watchdog runs only while the loader is waiting on the stream.
  assign to_clear = !rx_ready || accept;
  assign to_en    = rx_ready && !rx_valid;

  iram_loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (to_clear),
    .enable  (to_en),
    .expired (to_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    iram_we   = 1'b0;
    core_hold = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    start     = 1'b0;
    err_set   = 1'b0;
    err_val   = ERR_NONE;
    case (state)
      ST_IDLE: begin
        core_hold = 1'b0;
        if (load_start) begin
          state_nxt = ST_LEN;
          start     = 1'b1;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (last_byte) begin
            if (len_asm > DEPTH_WORDS) begin
              state_nxt = ST_ERR;
              err_set   = 1'b1;
              err_val   = ERR_LEN;
            end else if (len_asm == 32'd0) begin
              state_nxt = ST_TAIL;
            end else begin
              state_nxt = ST_DATA;
            end
          end
        end else if (to_exp) begin
          state_nxt = ST_ERR;
          err_set   = 1'b1;
          err_val   = ERR_TIMEOUT;
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (last_byte) state_nxt = ST_WRITE;
        end else if (to_exp) begin
          state_nxt = ST_ERR;
          err_set   = 1'b1;
          err_val   = ERR_TIMEOUT;
        end
      end
      ST_WRITE: begin
        iram_we   = 1'b1;
        state_nxt = last_word ? ST_TAIL : ST_DATA;
      end
`ifdef IRAM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (accept) begin
          if (csum_fin == 8'd0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_ERR;
            err_set   = 1'b1;
            err_val   = ERR_CSUM;
          end
        end else if (to_exp) begin
          state_nxt = ST_ERR;
          err_set   = 1'b1;
          err_val   = ERR_TIMEOUT;
        end
      end
`endif
      ST_DONE: begin
        core_hold = 1'b0;
        load_done = 1'b1;
        if (load_start) begin
          state_nxt = ST_LEN;
          start     = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        load_err = 1'b1;
        if (load_start) begin
          state_nxt = ST_LEN;
          start     = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      word_q <= '0;
      wcnt_q <= '0;
      bcnt_q <= '0;
      err_q  <= ERR_NONE;
`ifdef IRAM_LOADER_CSUM_EN
      csum_q <= '0;
`endif
    end else if (start) begin
      len_q  <= '0;
      word_q <= '0;
      wcnt_q <= '0;
      bcnt_q <= '0;
      err_q  <= ERR_NONE;
`ifdef IRAM_LOADER_CSUM_EN
      csum_q <= '0;
`endif
    end else begin
      if (accept && (state == ST_LEN)) begin
        len_q  <= len_asm;
        bcnt_q <= bcnt_q + 2'd1;
      end
      if (accept && (state == ST_DATA)) begin
        word_q <= word_asm;
        bcnt_q <= bcnt_q + 2'd1;
`ifdef IRAM_LOADER_CSUM_EN
        csum_q <= csum_q + rx_data;
`endif
      end
      if (iram_we) wcnt_q <= wcnt_q + 32'd1;
      if (err_set) err_q <= err_val;
    end
  end

  // Address and data are only meaningful alongside the strobe.
  assign iram_waddr   = iram_we ? wcnt_q : '0;
  assign iram_wdata   = iram_we ? word_q : '0;
  assign err_code     = err_q;
  assign words_loaded = wcnt_q;

endmodule

// File: tb/tb_iram_loader.sv
// Self-checking bench for iram_loader: table-driven frames, random frames
// against a byte-level reference model, and hand-written corner sequences.
module tb_iram_loader;
  import iram_loader_pkg::*;

  localparam int unsigned TO    = 16;
  localparam int unsigned DEPTH = DEPTH_WORDS_DEF;

  logic        clk = 1'b0, rst = 1'b1, load_start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready, iram_we, core_hold, load_done, load_err;
  logic [31:0] iram_waddr, iram_wdata, words_loaded;
  logic [1:0]  err_code;

  iram_loader #(.DEPTH_WORDS(DEPTH), .TIMEOUT_CYCLES(TO), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .iram_we(iram_we),
    .iram_waddr(iram_waddr), .iram_wdata(iram_wdata), .core_hold(core_hold),
    .load_done(load_done), .load_err(load_err), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Passive monitor: log of every write, completion pulses, handshake and error timing.
  logic [63:0] wr_log[$];
  int done_total = 0, hs_cyc = 0, err_rise_cyc = 0;
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    if (iram_we) wr_log.push_back({iram_waddr, iram_wdata});
    if (load_done) done_total++;
    if (rx_valid && rx_ready) hs_cyc = cyc + 1;
    if (load_err && !err_prev) err_rise_cyc = cyc;
    err_prev = load_err;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0]  tx_q[$];
  logic [63:0] exp_wr[$];

  task automatic build_frame(input int unsigned len, input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] w;
    int unsigned sum;
    tx_q.delete();
    for (int k = 0; k < 4; k++) tx_q.push_back(8'((len >> (8 * k)) % 256));
    if (len > DEPTH) return;
    sum = 0;
    for (int unsigned n = 0; n < len; n++) begin
      w = (n == 0) ? w0 : (n == 1) ? w1 : $urandom;
      for (int k = 0; k < 4; k++) begin
        tx_q.push_back(8'((w >> (8 * k)) % 256));
        sum += (w >> (8 * k)) % 256;
      end
    end
`ifdef IRAM_LOADER_CSUM_EN
    tx_q.push_back(8'((256 - (sum % 256)) % 256));
`endif
  endtask

  function automatic longint le_value(input int idx);
    longint v = 0;
    for (int k = 3; k >= 0; k--) v = v * 256 + longint'(tx_q[idx + k]);
    return v;
  endfunction

  // Reference: decode the frame from its bytes; returns the expected error code.
  function automatic logic [1:0] model_expect();
    longint len;
    int unsigned sum = 0;
    exp_wr.delete();
    len = le_value(0);
    if (len > DEPTH) return ERR_LEN;
    for (int n = 0; n < int'(len); n++) begin
      exp_wr.push_back({32'(n), 32'(le_value(4 + 4 * n))});
      for (int k = 0; k < 4; k++) sum += tx_q[4 + 4 * n + k];
    end
`ifdef IRAM_LOADER_CSUM_EN
    sum += tx_q[4 + 4 * int'(len)];
    if ((sum % 256) != 0) return ERR_CSUM;
`endif
    return ERR_NONE;
  endfunction

  task automatic start_load();
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
  endtask

  task automatic send(input int max_gap);
    int gap, budget;
    for (int i = 0; i < tx_q.size(); i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        rx_valid = 1'b0; rx_data = 8'($urandom);
        @(posedge clk); #1;
      end
      rx_valid = 1'b1; rx_data = tx_q[i];
      budget = 0;
      @(negedge clk);
      while (!rx_ready && budget < 40) begin @(negedge clk); budget++; end
      if (!rx_ready) begin
        check("send_ready", 64'(rx_ready), 64'd1);
        rx_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_end(input int done_base);
    int n = 0;
    while (n < 200 && done_total == done_base && !load_err) begin
      @(negedge clk); #1; n++;
    end
    check("finished", 64'(done_total != done_base || load_err), 64'd1);
    repeat (3) begin @(negedge clk); #1; end
  endtask

  task automatic run_case(input string name, input int max_gap, input bit poke,
                          input logic [1:0] exp_err, input int exp_words);
    int wbase, dbase;
    logic [1:0] merr;
    wbase = wr_log.size(); dbase = done_total;
    merr = model_expect();
    start_load();
    if (poke) begin
      fork
        send(max_gap);
        begin
          repeat (6) @(posedge clk);
          #1 load_start = 1'b1;
          @(posedge clk); #1 load_start = 1'b0;
        end
      join
    end else begin
      send(max_gap);
    end
    wait_end(dbase);
    check({name, "_nwr"}, 64'(wr_log.size() - wbase), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++) check({name, "_wr"}, wr_log[wbase + i], exp_wr[i]);
    check({name, "_done"}, 64'(done_total - dbase), 64'(exp_err == ERR_NONE));
    check({name, "_err"}, 64'(err_code), 64'(exp_err));
    check({name, "_merr"}, 64'(err_code), 64'(merr));
    check({name, "_lerr"}, 64'(load_err), 64'(exp_err != ERR_NONE));
    check({name, "_hold"}, 64'(core_hold), 64'(exp_err != ERR_NONE));
    check({name, "_words"}, 64'(words_loaded), 64'(exp_words));
  endtask

  task automatic check_idle_outs(input string name);
    check({name, "_ctl"}, 64'({rx_ready, iram_we, core_hold, load_done, load_err, err_code}), 64'd0);
    check({name, "_addr"}, 64'(iram_waddr), 64'd0);
    check({name, "_data"}, 64'(iram_wdata), 64'd0);
    check({name, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  typedef struct {
    int unsigned len;
    logic [31:0] w0;
    logic [31:0] w1;
    int          max_gap;
    logic [1:0]  exp_err;
    int          exp_words;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int wbase;
    int len;
    vecs[0] = '{2,    32'h12345678, 32'hDEADBEEF, 0, ERR_NONE, 2};
    vecs[1] = '{1,    32'h00000013, 32'h0,        3, ERR_NONE, 1};
    vecs[2] = '{8192, 32'h0,        32'h0,        0, ERR_LEN,  0};
    vecs[3] = '{0,    32'h0,        32'h0,        0, ERR_NONE, 0};
    vecs[4] = '{5,    32'hCAFEF00D, 32'h0BADF00D, 2, ERR_NONE, 5};

    repeat (3) @(posedge clk);
    #1 check_idle_outs("rst_held");
    rst = 1'b0;
    @(negedge clk); #1 check_idle_outs("rst_rel");

    for (int i = 0; i < 5; i++) begin
      wbase = wr_log.size();
      build_frame(vecs[i].len, vecs[i].w0, vecs[i].w1);
      run_case($sformatf("vec%0d", i), vecs[i].max_gap, 1'b0, vecs[i].exp_err, vecs[i].exp_words);
      if (i == 0) begin
        check("vec0_w0", wr_log[wbase],     {32'd0, 32'h12345678});
        check("vec0_w1", wr_log[wbase + 1], {32'd1, 32'hDEADBEEF});
      end
    end

    for (int r = 0; r < 4; r++) begin
      len = int'($urandom_range(6, 1));
      build_frame(len, $urandom, $urandom);
      run_case($sformatf("rnd%0d", r), int'($urandom_range(4, 0)), 1'b0, ERR_NONE, len);
    end

    build_frame(3, $urandom, $urandom);
    run_case("poke", 0, 1'b1, ERR_NONE, 3);

`ifdef IRAM_LOADER_CSUM_EN
    build_frame(1, 32'h04030201, 32'h0);
    check("csum_byte", 64'(tx_q[8]), 64'hF6);
    run_case("csum_ok", 0, 1'b0, ERR_NONE, 1);
    tx_q[8] = 8'hF7;
    run_case("csum_bad", 0, 1'b0, ERR_CSUM, 1);
`endif

    // Stream stalls after two data bytes: error lands exactly TO idle cycles later.
    build_frame(3, 32'h11223344, 32'h55667788);
    while (tx_q.size() > 6) tx_q.delete(tx_q.size() - 1);
    wbase = wr_log.size();
    start_load();
    send(0);
    for (int n = 0; n < 60 && !load_err; n++) begin @(negedge clk); #1; end
    check("to_delay", 64'(err_rise_cyc - hs_cyc), 64'(TO));
    check("to_err", 64'(err_code), 64'(ERR_TIMEOUT));
    check("to_lerr", 64'(load_err), 64'd1);
    check("to_hold", 64'(core_hold), 64'd1);
    check("to_nwr", 64'(wr_log.size() - wbase), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    #1 check_idle_outs("to_rst");
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iram_loader.md
Name: iram_loader

Overview:
- Boot-time writer for the instruction RAM write port.
- Receives a byte stream from the UART receive path, with valid/ready handshaking.
- Assembles little-endian 32-bit words and drives the instruction RAM's we/waddr/wdata.
- Holds the core in reset while loading and reports done or error.

Parameters:
- DEPTH_WORDS, 8191: capacity of the instruction RAM in words; the largest accepted image length.
- TIMEOUT_CYCLES, 1000000: maximum idle clocks allowed between accepted bytes while loading.
- CNT_W, 20: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  Single clock domain.
- rst  in  1  Asynchronous, active-high reset.
- load_start  in  1  One-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- rx_data  in  8  Stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  Loader accepts a byte this cycle; transfer occurs when rx_valid and rx_ready are both high.
- iram_we  out  1  One-cycle write strobe to the instruction RAM.
- iram_waddr  out  32  Word index, not a byte address: word n goes to index n.
- iram_wdata  out  32  Assembled word.
- core_hold  out  1  Keeps the core in reset while high.
- load_done  out  1  One-cycle pulse on successful completion.
- load_err  out  1  Sticky error flag.
- err_code  out  2  Error cause: 0 none, 1 length, 2 timeout, 3 checksum.
- words_loaded  out  32  Count of words written in the current or last load.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; byte counter, word index and timeout counter cleared.
- A rst assertion mid-load aborts immediately. No further writes occur, and a partially loaded RAM is left as is.
- Frame format: 4-byte little-endian length L (in words), then L×4 data bytes, each word little-endian.
- FSM states: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR.
- IDLE: rx_ready=0; core_hold=0. On load_start, go to LEN, set core_hold=1, clear words_loaded, err_code and load_err.
- LEN: rx_ready=1; shift in 4 bytes. After the 4th byte:
  - L > DEPTH_WORDS: go to ERR, err_code=1.
  - L = 0: go to CSUM if the macro is defined, else DONE.
  - Otherwise go to DATA.
- DATA: rx_ready=1; accumulate bytes into the word register (byte 0 in [7:0]). The 4th accepted byte moves to WRITE.
- WRITE: rx_ready=0 for one cycle.
  - iram_we=1, iram_waddr = word index, iram_wdata = assembled word.
  - Word index and words_loaded increment.
  - If words_loaded reaches L, go to CSUM or DONE; else back to DATA.
  - Write latency: the write occurs in the cycle after the 4th byte handshake.
- DONE: load_done=1 for exactly one cycle and core_hold drops in the same cycle. The next state is IDLE.
- ERR: core_hold remains 1 so a partial image never executes. load_err=1 until the next load_start, which restarts at LEN.
- Timeout: the counter resets on every accepted byte and on entry to LEN. It increments in LEN, DATA and CSUM while no byte is accepted. On reaching TIMEOUT_CYCLES, go to ERR with err_code=2. A byte accepted in the same cycle takes priority and clears the counter.
- load_start in LEN, DATA, WRITE or CSUM is ignored.
- rx_valid in IDLE, DONE or ERR is not accepted and is not buffered.
- Word index arithmetic is unsigned 32-bit. The length check guarantees it never exceeds DEPTH_WORDS-1, so it never wraps.

Optional Feature:
- Macro: IRAM_LOADER_CSUM_EN.
- Defined: one trailing checksum byte follows the data and is accepted in CSUM with rx_ready=1.
  - An 8-bit running sum of all data bytes plus the checksum byte must equal 0x00 mod 256; the length bytes are excluded.
  - Sum is zero: go to DONE. Nonzero: go to ERR with err_code=3.
  - The timeout also applies in CSUM.
- Not defined: the CSUM state and checksum logic are absent; the last write goes directly to DONE, and err_code 3 is never produced.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - err_code constants ERR_NONE, ERR_LEN, ERR_TIMEOUT, ERR_CSUM;
  - default DEPTH_WORDS, kept shared with the instruction RAM depth.
- One natural sub-module, iram_loader_timeout: a loadable down/up counter with clear, enable and expiry outputs. All other logic stays in the top module.

Test Plan:
- Length 2, bytes 78 56 34 12 EF BE AD DE, no stalls:
  - iram_we at index 0 with 0x12345678, then index 1 with 0xDEADBEEF;
  - load_done pulses once; core_hold falls; words_loaded=2.
- rx_valid toggled randomly with 3-cycle gaps, length 1, word 0x00000013: single write at index 0 with 0x00000013; no spurious iram_we.
- Length 8192 (DEPTH_WORDS+1): ERR after the 4th length byte, err_code=1, no iram_we, core_hold stays 1. A following load_start with length 0 gives load_done, with err_code and load_err cleared.
- Stream stops after 2 data bytes, TIMEOUT_CYCLES set to 16: ERR exactly 16 idle cycles after the last accepted byte, err_code=2. rst then returns all outputs to 0.
- With IRAM_LOADER_CSUM_EN, length 1, data 01 02 03 04:
  - checksum 0xF6: load_done;
  - checksum 0xF7: err_code=3, load_err=1.
- load_start pulsed while in DATA: ignored, and the load completes normally with the expected words_loaded.
